// File: rtl/membus_arbiter.sv
// Shared-memory bus arbiter: port 0 (CPU) has priority, renderer ports share round-robin,
// and a renderer starved by port 0 for MAX_WAIT cycles is promoted for one grant.
module membus_arbiter #(
   parameter int NUM_PORTS  = 4,
   parameter int ADDR_WIDTH = 18,
   parameter int RD_LATENCY = 1,
   parameter int MAX_WAIT   = 15
) (
   input  logic                             clk25,
   input  logic                             reset,
   input  logic [NUM_PORTS-1:0]             port_strobe,
   input  logic [NUM_PORTS-1:0]             port_write,
   input  logic [NUM_PORTS*ADDR_WIDTH-1:0]  port_addr,
   input  logic [NUM_PORTS*8-1:0]           port_wrdata,
   output logic [NUM_PORTS-1:0]             port_grant,
   output logic [NUM_PORTS-1:0]             port_ack,
   output logic [31:0]                      port_rddata,
   output logic                             mem_strobe,
   output logic                             mem_write,
   output logic [ADDR_WIDTH-1:0]            mem_addr,
   output logic [31:0]                      mem_wrdata,
   output logic [3:0]                       mem_bytesel,
   input  logic [31:0]                      mem_rddata
);

   localparam int PW = $clog2(NUM_PORTS);

   logic [PW-1:0]         r_rr_ptr;
   logic [7:0]            r_wait_cnt;
   logic [RD_LATENCY-1:0] r_pipe_vld;
   logic [PW-1:0]         r_pipe_idx [RD_LATENCY];

   logic                  w_rend_any;
   logic                  w_rend_vld;
   logic [PW-1:0]         w_rend_idx;
   logic                  w_take0;
   logic                  w_gnt_vld;
   logic [PW-1:0]         w_gnt_idx;
   logic [ADDR_WIDTH-1:0] w_addr;

   assign w_rend_any = |port_strobe[NUM_PORTS-1:1];

   // First requesting renderer, scanning rr_ptr upward and wrapping within 1..NUM_PORTS-1.
   always_comb begin
      int unsigned v_p;
      logic [PW-1:0] v_idx;
      w_rend_vld = 1'b0;
      w_rend_idx = '0;
      v_p        = 0;
      v_idx      = '0;
      for (int unsigned k = 0; k < NUM_PORTS - 1; k++) begin
         v_p = 32'(r_rr_ptr) + k;
         if (v_p >= NUM_PORTS) v_p = v_p - (NUM_PORTS - 1);
         v_idx = v_p[PW-1:0];
         if (!w_rend_vld && port_strobe[v_idx]) begin
            w_rend_vld = 1'b1;
            w_rend_idx = v_idx;
         end
      end
   end

   assign w_take0   = port_strobe[0] && !(w_rend_vld && (r_wait_cnt == 8'(MAX_WAIT)));
   assign w_gnt_vld = w_take0 || w_rend_vld;
   assign w_gnt_idx = w_take0 ? '0 : w_rend_idx;
   assign w_addr    = port_addr[int'(w_gnt_idx)*ADDR_WIDTH +: ADDR_WIDTH];

   always_comb begin
      port_grant  = '0;
      mem_strobe  = 1'b0;
      mem_write   = 1'b0;
      mem_addr    = '0;
      mem_wrdata  = '0;
      mem_bytesel = '0;
      if (w_gnt_vld) begin
         port_grant[w_gnt_idx] = 1'b1;
         mem_strobe  = 1'b1;
         mem_write   = port_write[w_gnt_idx];
         mem_addr    = w_addr;
         mem_wrdata  = {4{port_wrdata[int'(w_gnt_idx)*8 +: 8]}};
         mem_bytesel = 4'b0001 << w_addr[1:0];
      end
   end

   always_ff @(posedge clk25 or posedge reset) begin
      if (reset) begin
         r_rr_ptr   <= PW'(1);
         r_wait_cnt <= '0;
         r_pipe_vld <= '0;
         for (int unsigned i = 0; i < RD_LATENCY; i++) r_pipe_idx[i] <= '0;
      end else begin
         if (w_gnt_vld && !w_take0)
            r_rr_ptr <= (w_rend_idx == PW'(NUM_PORTS - 1)) ? PW'(1) : w_rend_idx + 1'b1;

         if (!w_rend_any || (w_gnt_vld && !w_take0))
            r_wait_cnt <= '0;
         else if (w_take0 && (r_wait_cnt < 8'(MAX_WAIT)))
            r_wait_cnt <= r_wait_cnt + 8'd1;

         r_pipe_vld[0] <= w_gnt_vld;
         r_pipe_idx[0] <= w_gnt_idx;
         for (int unsigned i = 1; i < RD_LATENCY; i++) begin
            r_pipe_vld[i] <= r_pipe_vld[i-1];
            r_pipe_idx[i] <= r_pipe_idx[i-1];
         end
      end
   end

   always_comb begin
      port_ack = '0;
      if (r_pipe_vld[RD_LATENCY-1]) port_ack[r_pipe_idx[RD_LATENCY-1]] = 1'b1;
   end

   assign port_rddata = mem_rddata;

endmodule

// File: tb/tb_membus_arbiter.sv
// Bench for membus_arbiter: two instances (read latency 1 and 3) share stimulus and are
// checked every cycle against a queue-based priority model, plus directed literal cases.
module tb_membus_arbiter;
   localparam int NP = 4;
   localparam int AW = 18;
   localparam int MW = 3;

   logic            clk25 = 1'b0;
   logic            reset = 1'b0;
   logic [NP-1:0]   strobe = '0;
   logic [NP-1:0]   wr = '0;
   logic [NP*AW-1:0] addr = '0;
   logic [NP*8-1:0] wd = '0;
   logic [31:0]     mrd = '0;

   logic [NP-1:0] g_a, ack_a, g_b, ack_b;
   logic [31:0]   rd_a, rd_b, mwd_a, mwd_b;
   logic          ms_a, mw_a, ms_b, mw_b;
   logic [AW-1:0] ma_a, ma_b;
   logic [3:0]    mbs_a, mbs_b;

   int checks = 0;
   int errors = 0;
   int m_rr = 1;
   int m_wait = 0;
   int qa[$];
   int qb[$];

   always #20 clk25 = ~clk25;

   membus_arbiter #(.NUM_PORTS(NP), .ADDR_WIDTH(AW), .RD_LATENCY(1), .MAX_WAIT(MW)) dut_a (
      .clk25(clk25), .reset(reset), .port_strobe(strobe), .port_write(wr),
      .port_addr(addr), .port_wrdata(wd), .port_grant(g_a), .port_ack(ack_a),
      .port_rddata(rd_a), .mem_strobe(ms_a), .mem_write(mw_a), .mem_addr(ma_a),
      .mem_wrdata(mwd_a), .mem_bytesel(mbs_a), .mem_rddata(mrd));

   membus_arbiter #(.NUM_PORTS(NP), .ADDR_WIDTH(AW), .RD_LATENCY(3), .MAX_WAIT(MW)) dut_b (
      .clk25(clk25), .reset(reset), .port_strobe(strobe), .port_write(wr),
      .port_addr(addr), .port_wrdata(wd), .port_grant(g_b), .port_ack(ack_b),
      .port_rddata(rd_b), .mem_strobe(ms_b), .mem_write(mw_b), .mem_addr(ma_b),
      .mem_wrdata(mwd_b), .mem_bytesel(mbs_b), .mem_rddata(mrd));

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Winner under the priority rules; -1 when nobody requests.
   function automatic int model_grant();
      int cand;
      int p;
      cand = -1;
      for (int k = 0; k < NP - 1; k++) begin
         p = 1 + ((m_rr - 1 + k) % (NP - 1));
         if (cand < 0 && strobe[p]) cand = p;
      end
      if (strobe[0] && !(cand >= 0 && m_wait == MW)) return 0;
      return cand;
   endfunction

   function automatic logic [NP-1:0] onehot(input int p);
      logic [NP-1:0] v;
      v = '0;
      if (p >= 0) v[p] = 1'b1;
      return v;
   endfunction

   task automatic model_init();
      m_rr = 1;
      m_wait = 0;
      qa = '{-1};
      qb = '{-1, -1, -1};
   endtask

   always @(posedge clk25 or posedge reset) begin
      int g;
      if (reset) begin
         model_init();
      end else begin
         g = model_grant();
         void'(qa.pop_front());
         qa.push_back(g);
         void'(qb.pop_front());
         qb.push_back(g);
         if (g > 0) m_rr = (g == NP - 1) ? 1 : g + 1;
         if (g > 0 || strobe[NP-1:1] == '0) m_wait = 0;
         else if (g == 0 && m_wait < MW) m_wait++;
      end
   end

   always @(negedge clk25) begin
      int g;
      logic [AW-1:0] ea;
      logic ew;
      logic [31:0] ewd;
      logic [3:0] ebs;
      g = model_grant();
      ea = '0; ew = 1'b0; ewd = '0; ebs = '0;
      if (g >= 0) begin
         ea  = addr[g*AW +: AW];
         ew  = wr[g];
         ewd = {4{wd[g*8 +: 8]}};
         ebs = 4'b0001 << ea[1:0];
      end
      chk("grant_a", g_a, onehot(g));
      chk("grant_b", g_b, onehot(g));
      chk("strobe_a", ms_a, g >= 0);
      chk("strobe_b", ms_b, g >= 0);
      chk("write_a", mw_a, ew);
      chk("write_b", mw_b, ew);
      chk("addr_a", ma_a, ea);
      chk("addr_b", ma_b, ea);
      chk("wrdata_a", mwd_a, ewd);
      chk("wrdata_b", mwd_b, ewd);
      chk("bytesel_a", mbs_a, ebs);
      chk("bytesel_b", mbs_b, ebs);
      chk("ack_a", ack_a, onehot(qa[0]));
      chk("ack_b", ack_b, onehot(qb[0]));
      chk("rddata_a", rd_a, mrd);
      chk("rddata_b", rd_b, mrd);
   end

   task automatic cyc();
      @(posedge clk25);
      #1;
   endtask

   task automatic pulse_reset();
      reset = 1'b1;
      cyc();
      reset = 1'b0;
   endtask

   task automatic set_port(input int p, input logic w, input logic [AW-1:0] a, input logic [7:0] d);
      wr[p] = w;
      addr[p*AW +: AW] = a;
      wd[p*8 +: 8] = d;
   endtask

   logic [3:0] ord32 [6] = '{4'b0010, 4'b0100, 4'b1000, 4'b0010, 4'b0100, 4'b1000};
   logic [3:0] ord33 [8] = '{4'b0001, 4'b0001, 4'b0001, 4'b0100, 4'b0001, 4'b0001, 4'b0001, 4'b0100};
   logic [3:0] ord36 [4] = '{4'b0001, 4'b0001, 4'b0001, 4'b0010};

   initial begin
      model_init();
      #1 reset = 1'b1;
      @(negedge clk25);
      chk("reset_ack_a", ack_a, 4'b0000);
      chk("reset_ack_b", ack_b, 4'b0000);
      cyc();
      cyc();
      reset = 1'b0;

      // Single read from port 1, latency 1.
      mrd = 32'hAABBCCDD;
      set_port(1, 1'b0, 18'h00005, 8'h00);
      strobe = 4'b0010;
      @(negedge clk25);
      chk("rd1_grant", g_a, 4'b0010);
      chk("rd1_bytesel", mbs_a, 4'b0010);
      cyc();
      strobe = '0;
      @(negedge clk25);
      chk("rd1_ack", ack_a, 4'b0010);
      chk("rd1_rddata", rd_a, 32'hAABBCCDD);
      cyc();

      // Renderers only: round robin from port 1.
      pulse_reset();
      strobe = 4'b1110;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk25);
         chk("rr_order", g_a, ord32[i]);
         if (i > 0) chk("rr_ack", ack_a, ord32[i-1]);
         cyc();
      end

      // Port 0 vs port 2 with promotion after MAX_WAIT losses.
      strobe = '0;
      pulse_reset();
      strobe = 4'b0101;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk25);
         chk("starve_order", g_a, ord33[i]);
         cyc();
      end

      // Port 0 byte write.
      strobe = '0;
      pulse_reset();
      set_port(0, 1'b1, 18'h00003, 8'h5A);
      strobe = 4'b0001;
      @(negedge clk25);
      chk("wr_write", mw_a, 1'b1);
      chk("wr_wrdata", mwd_a, 32'h5A5A5A5A);
      chk("wr_bytesel", mbs_a, 4'b1000);
      cyc();
      strobe = '0;
      @(negedge clk25);
      chk("wr_ack_lat1", ack_a, 4'b0001);
      cyc();
      cyc();
      @(negedge clk25);
      chk("wr_ack_lat3", ack_b, 4'b0001);
      cyc();

      // All ports strobing: port 0 wins until the wait count saturates.
      pulse_reset();
      strobe = 4'b1111;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk25);
         chk("all_order", g_a, ord36[i]);
         cyc();
      end

      // Reset one cycle after a latency-3 grant drops the ack and restores rr_ptr.
      strobe = '0;
      pulse_reset();
      set_port(1, 1'b0, 18'h00010, 8'h00);
      strobe = 4'b0010;
      @(negedge clk25);
      chk("flush_grant", g_b, 4'b0010);
      cyc();
      strobe = '0;
      reset = 1'b1;
      @(negedge clk25);
      chk("flush_ack_in_reset", ack_b, 4'b0000);
      cyc();
      cyc();
      reset = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk25);
         chk("flush_no_ack", ack_b, 4'b0000);
         cyc();
      end
      strobe = 4'b1110;
      @(negedge clk25);
      chk("flush_rr_ptr", g_b, 4'b0010);
      cyc();

      // Random traffic with occasional mid-flight resets.
      for (int n = 0; n < 3000; n++) begin
         mrd = $urandom;
         for (int p = 0; p < NP; p++) begin
            strobe[p] = ($urandom_range(0, 99) < 55);
            set_port(p, 1'(($urandom_range(0, 1))), AW'($urandom), 8'($urandom));
         end
         if ($urandom_range(0, 149) == 0) reset = 1'b1;
         cyc();
         reset = 1'b0;
      end

      strobe = '0;
      cyc();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
